// File: rtl/pipe_reg_fd_if.sv
// Fetch/Decode boundary bundle: hazard controls, F-stage fields in, D-stage fields
// and performance counters out. The master side is the fetch stage plus the hazard
// unit. The slave side is the pipeline register.
interface pipe_reg_fd_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  StallD;
    logic                  FlushD;
    logic                  ValidF;
    logic [DATA_WIDTH-1:0] PCF;
    logic [DATA_WIDTH-1:0] InstrF;
    logic [DATA_WIDTH-1:0] PCPlus4F;
    logic [DATA_WIDTH-1:0] PCD;
    logic [DATA_WIDTH-1:0] InstrD;
    logic [DATA_WIDTH-1:0] PCPlus4D;
    logic                  ValidD;
    logic [CNT_WIDTH-1:0]  StallCnt;
    logic [CNT_WIDTH-1:0]  FlushCnt;

    modport master (
        output StallD, FlushD, ValidF, PCF, InstrF, PCPlus4F,
        input  PCD, InstrD, PCPlus4D, ValidD, StallCnt, FlushCnt
    );

    modport slave (
        input  StallD, FlushD, ValidF, PCF, InstrF, PCPlus4F,
        output PCD, InstrD, PCPlus4D, ValidD, StallCnt, FlushCnt
    );
endinterface

// File: rtl/pipe_reg_fd.sv
// Fetch->Decode pipeline register with stall (hold), flush (canonical NOP bubble),
// a valid bit, and saturating stall/flush event counters. Every output comes
// straight from a flop. Reset is synchronous.
module pipe_reg_fd #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013,
    parameter int                    CNT_WIDTH  = 16
) (
    input logic          clk,
    input logic          rst,
    pipe_reg_fd_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] instr_d;
    logic [DATA_WIDTH-1:0] pc_plus4_d;
    logic                  valid_d;
    logic [CNT_WIDTH-1:0]  stall_cnt;
    logic [CNT_WIDTH-1:0]  flush_cnt;

    // D-stage fields. Priority is reset, then flush (a bubble, even while stalled),
    // then stall (hold), then load from F.
    always_ff @(posedge clk) begin
        if (rst || bus.FlushD) begin
            pc_d       <= '0;
            instr_d    <= NOP_INSTR;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (!bus.StallD) begin
            pc_d       <= bus.PCF;
            instr_d    <= bus.InstrF;
            pc_plus4_d <= bus.PCPlus4F;
            valid_d    <= bus.ValidF;
        end
    end

    // Stall counter: counts only stalls that take effect. A flush on the same edge
    // overrides the stall, so that edge is not counted. The counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (bus.StallD && !bus.FlushD && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    // Flush counter: counts every flush edge, whether or not a stall is also
    // requested. The counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (bus.FlushD && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

    assign bus.PCD      = pc_d;
    assign bus.InstrD   = instr_d;
    assign bus.PCPlus4D = pc_plus4_d;
    assign bus.ValidD   = valid_d;
    assign bus.StallCnt = stall_cnt;
    assign bus.FlushCnt = flush_cnt;
endmodule

// File: tb/tb_pipe_reg_fd.sv
// Bench for pipe_reg_fd. Two instances receive the same stimulus: one with 16-bit
// counters and one with 4-bit counters, so saturation is reachable. A rule-level
// reference model tracks the expected D-stage contents and raw event counts.
module tb_pipe_reg_fd;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        validf;
    logic [31:0] pcf;
    logic [31:0] instrf;
    logic [31:0] pc4f;

    int total = 0;
    int bad   = 0;

    // Reference model state. The counters hold raw event counts since the last
    // reset; saturation is applied only when comparing.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    longint      m_sc;
    longint      m_fc;

    pipe_reg_fd_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus_a ();
    pipe_reg_fd_if #(.DATA_WIDTH(32), .CNT_WIDTH(4))  bus_b ();

    assign bus_a.StallD   = stall;
    assign bus_a.FlushD   = flush;
    assign bus_a.ValidF   = validf;
    assign bus_a.PCF      = pcf;
    assign bus_a.InstrF   = instrf;
    assign bus_a.PCPlus4F = pc4f;
    assign bus_b.StallD   = stall;
    assign bus_b.FlushD   = flush;
    assign bus_b.ValidF   = validf;
    assign bus_b.PCF      = pcf;
    assign bus_b.InstrF   = instrf;
    assign bus_b.PCPlus4F = pc4f;

    pipe_reg_fd #(.DATA_WIDTH(32), .NOP_INSTR(NOP), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );
    pipe_reg_fd #(.DATA_WIDTH(32), .NOP_INSTR(NOP), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    // Free-running clock with a 10-time-unit period.
    always #5 clk = ~clk;

    function automatic logic [31:0] sat(longint n, longint maxv);
        return (n > maxv) ? 32'(maxv) : 32'(n);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pcd_a",      bus_a.PCD,                m_pc);
        chk("instrd_a",   bus_a.InstrD,             m_instr);
        chk("pc4d_a",     bus_a.PCPlus4D,           m_pc4);
        chk("validd_a",   {31'd0, bus_a.ValidD},    {31'd0, m_valid});
        chk("stallcnt16", {16'd0, bus_a.StallCnt},  sat(m_sc, 65535));
        chk("flushcnt16", {16'd0, bus_a.FlushCnt},  sat(m_fc, 65535));
        chk("pcd_b",      bus_b.PCD,                m_pc);
        chk("instrd_b",   bus_b.InstrD,             m_instr);
        chk("stallcnt4",  {28'd0, bus_b.StallCnt},  sat(m_sc, 15));
        chk("flushcnt4",  {28'd0, bus_b.FlushCnt},  sat(m_fc, 15));
        if (bus_a.ValidD === 1'b0) chk("bubble_nop", bus_a.InstrD, NOP);
    endtask

    // Advance one rising edge, apply the update rules to the model, then check
    // the outputs 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_pc = 0; m_instr = NOP; m_pc4 = 0; m_valid = 0; m_sc = 0; m_fc = 0;
        end else if (flush) begin
            m_pc = 0; m_instr = NOP; m_pc4 = 0; m_valid = 0; m_fc++;
        end else if (stall) begin
            m_sc++;
        end else begin
            m_pc = pcf; m_instr = instrf; m_pc4 = pc4f; m_valid = validf;
        end
        #1;
        check_all();
    endtask

    // Random F-stage fields. When ValidF is 0 the instruction is the NOP,
    // as the fetch stage would present it.
    task automatic rnd_fetch();
        pcf    = $urandom & 32'hFFFF_FFFC;
        pc4f   = pcf + 32'd4;
        validf = ($urandom_range(0, 3) != 0);
        instrf = validf ? $urandom : NOP;
    endtask

    initial begin
        // Reset for 2 cycles with random inputs present.
        rnd_fetch();
        stall = $urandom_range(0, 1) == 1;
        flush = $urandom_range(0, 1) == 1;
        rst = 1'b1;
        step();
        rnd_fetch();
        step();
        chk("rst_pcd",   bus_a.PCD,               32'h0);
        chk("rst_instr", bus_a.InstrD,            32'h00000013);
        chk("rst_valid", {31'd0, bus_a.ValidD},   32'h0);
        chk("rst_scnt",  {16'd0, bus_a.StallCnt}, 32'h0);
        chk("rst_fcnt",  {16'd0, bus_a.FlushCnt}, 32'h0);

        // Basic load.
        rst = 0; stall = 0; flush = 0; validf = 1;
        pcf = 32'h100; instrf = 32'h00500093; pc4f = 32'h104;
        step();
        chk("load_pcd",   bus_a.PCD,              32'h100);
        chk("load_instr", bus_a.InstrD,           32'h00500093);
        chk("load_pc4",   bus_a.PCPlus4D,         32'h104);
        chk("load_valid", {31'd0, bus_a.ValidD},  32'h1);

        // Three stall cycles while the fetch stage presents new values.
        stall = 1; pcf = 32'h200; instrf = 32'h00A00113; pc4f = 32'h204;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_pcd",   bus_a.PCD,    32'h100);
            chk("stall_hold_instr", bus_a.InstrD, 32'h00500093);
        end
        chk("stall_cnt3", {16'd0, bus_a.StallCnt}, 32'd3);
        stall = 0;
        step();
        chk("release_pcd", bus_a.PCD, 32'h200);

        // Flush takes priority over a simultaneous stall.
        stall = 1; flush = 1;
        step();
        chk("fvs_instr", bus_a.InstrD,            NOP);
        chk("fvs_valid", {31'd0, bus_a.ValidD},   32'h0);
        chk("fvs_pcd",   bus_a.PCD,               32'h0);
        chk("fvs_fcnt",  {16'd0, bus_a.FlushCnt}, 32'd1);
        chk("fvs_scnt",  {16'd0, bus_a.StallCnt}, 32'd3);

        // Saturation: 20 more stall cycles.
        flush = 0; stall = 1;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt4",  {28'd0, bus_b.StallCnt}, 32'd15);
        chk("sat_cnt16", {16'd0, bus_a.StallCnt}, 32'd23);

        // Reset in the middle of a stall, with StallCnt at 5.
        stall = 0; rst = 1;
        step();
        rst = 0; stall = 1;
        for (int i = 0; i < 5; i++) step();
        chk("pre_rst_scnt", {16'd0, bus_a.StallCnt}, 32'd5);
        rst = 1;
        step();
        chk("midrst_scnt", {16'd0, bus_a.StallCnt}, 32'd0);
        chk("midrst_pcd",  bus_a.PCD,               32'h0);
        rst = 0; stall = 0; rnd_fetch();
        step();
        chk("post_rst_load", bus_a.PCD, pcf);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rnd_fetch();
            stall = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 4) == 0);
            rst   = ($urandom_range(0, 60) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_reg_fd.md
Name: pipe_reg_fd

Overview:
Parametrised Fetch→Decode pipeline register for the 5-stage RV32I pipeline. It carries PC, instruction and PC+4 from F to D, with a one-cycle latency. Compared with a plain register it adds:
- stall (hold)
- flush (bubble insertion as a canonical NOP)
- a valid bit
- saturating stall and flush event counters for performance debug

The hazard unit drives it, and it feeds the decode stage and register-file read.

Parameters:
- DATA_WIDTH, 32, width of the PC, instruction and PC+4 fields.
- NOP_INSTR, 32'h00000013, instruction injected on flush or reset (addi x0,x0,0); its width is DATA_WIDTH.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- StallD  input  1  hold current D-stage contents (from hazard unit).
- FlushD  input  1  replace D-stage contents with a bubble (from hazard unit).
- ValidF  input  1  F-stage holds a real instruction.
- PCF  input  DATA_WIDTH  fetch-stage PC.
- InstrF  input  DATA_WIDTH  fetched instruction.
- PCPlus4F  input  DATA_WIDTH  fetch-stage PC+4.
- PCD  output  DATA_WIDTH  decode-stage PC.
- InstrD  output  DATA_WIDTH  decode-stage instruction.
- PCPlus4D  output  DATA_WIDTH  decode-stage PC+4.
- ValidD  output  1  decode-stage instruction is real, not a bubble.
- StallCnt  output  CNT_WIDTH  number of cycles with StallD=1 applied (saturating).
- FlushCnt  output  CNT_WIDTH  number of cycles with FlushD=1 applied (saturating).

Behaviour:
- Interface:
  - One clock, clk.
  - rst is synchronous and active-high; it acts only on a rising clk edge while rst=1.
- Register update priority, evaluated each rising edge, highest first:
  1. rst: PCD=0, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, StallCnt=0, FlushCnt=0.
  2. FlushD=1: PCD=0, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0. This applies whatever StallD is; flush beats stall.
  3. StallD=1: PCD, InstrD, PCPlus4D and ValidD all hold their current values.
  4. Otherwise (load): PCD←PCF, InstrD←InstrF, PCPlus4D←PCPlus4F, ValidD←ValidF.
- Latency:
  - Exactly one cycle from F inputs to D outputs on a load.
  - Outputs come directly from flops, with no combinational path from inputs to outputs.
- Counters:
  - StallCnt increments by 1 on an edge where rst=0, StallD=1 and FlushD=0.
  - FlushCnt increments by 1 on an edge where rst=0 and FlushD=1; this includes the StallD=1 case.
  - Each counter saturates at 2^CNT_WIDTH−1 and never wraps.
  - Counters are not cleared by flush; only rst clears them.
- Bubble semantics:
  - While ValidD=0, InstrD is always NOP_INSTR.
  - Exception: when ValidF=0 is loaded, InstrD takes InstrF as given. The fetch stage guarantees InstrF=NOP_INSTR whenever ValidF=0.
- Reset mid-operation:
  - rst asserted during a stall or flush forces the reset values on the next edge.
  - The first edge after rst deasserts follows the normal priority rules.
- Stall persistence: holding StallD for N consecutive cycles keeps the outputs constant for N edges, and StallCnt increases by N (saturating).
- Parameter widths:
  - Every field is DATA_WIDTH wide; no truncation or extension occurs inside the block.
  - NOP_INSTR is sized to DATA_WIDTH.

Test Plan:
1. Reset: rst=1 for 2 cycles with random inputs → PCD=0, InstrD=0x00000013, PCPlus4D=0, ValidD=0, StallCnt=0, FlushCnt=0.
2. Load:
   - Stimulus: PCF=0x100, InstrF=0x00500093, PCPlus4F=0x104, ValidF=1, StallD=FlushD=0.
   - Response: one edge later, PCD=0x100, InstrD=0x00500093, PCPlus4D=0x104, ValidD=1.
3. Stall:
   - Stimulus: after scenario 2, StallD=1 for 3 cycles while PCF=0x200 and InstrF=0x00A00113.
   - Response: D outputs stay 0x100/0x00500093/0x104/1 throughout and StallCnt=3. On release, the next edge loads 0x200.
4. Flush beats stall: StallD=1 and FlushD=1 on the same edge → InstrD=0x00000013, ValidD=0, PCD=0, FlushCnt increments by 1, StallCnt unchanged.
5. Saturation: with CNT_WIDTH=4, hold StallD=1 for 20 cycles → StallCnt reaches 15 and stays at 15.
6. Reset mid-stall: StallD=1 with StallCnt=5, then pulse rst for 1 cycle → all outputs and counters reach their reset values. The next load edge with StallD=0 captures the F inputs normally.
